// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings and field widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam int UART_BYTE_W   = 8;
  localparam int TIMEOUT_CNT_W = 4;
  localparam int WDOG_W        = 16;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: one-hot grant of the first request after the previous owner.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to act on o_grant.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_found
);

  // Walk the ring starting just after the previous owner; the first hit wins,
  // so the previous owner itself is examined last.
  always_comb begin
    logic [IDX_W-1:0] w_idx;
    o_grant = '0;
    o_found = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = IDX_W'((int'(i_last) + i) % NUM_REQ);
      if (!o_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX byte engine among NUM_REQ framed valid/ready requesters, round-robin per frame.
// Latency: grant 1 cycle after valid in IDLE; tx_start_o 1 cycle after each accepted byte.
// Backpressure: one byte in flight; ready only to the owner in SEND, owner stalls revoked by watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                           sys_clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]             req_last_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           tx_start_o,
  output logic [UART_BYTE_W-1:0]         tx_data_o,
  input  logic                           tx_busy_i,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic [TIMEOUT_CNT_W-1:0]       timeout_cnt_o
);

  localparam int                       IDX_W    = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]         LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [WDOG_W-1:0]        WD_MAX   = WDOG_W'(TIMEOUT_CYC - 1);
  localparam logic [TIMEOUT_CNT_W-1:0] TMO_SAT  = '1;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [NUM_REQ-1:0]         r_grant;
  logic [IDX_W-1:0]           r_last_idx;
  logic [WDOG_W-1:0]          r_wd;
  logic [TIMEOUT_CNT_W-1:0]   r_tmo_cnt;
  logic [UART_BYTE_W-1:0]     r_data;
  logic                       r_last_q;
  logic                       r_start;

  logic [NUM_REQ-1:0]         w_pick;
  logic                       w_found;
  logic                       w_sel_vld;
  logic                       w_sel_last;
  logic [UART_BYTE_W-1:0]     w_sel_dat;
  logic [IDX_W-1:0]           w_gidx;
  logic                       w_xfer;
  logic                       w_wd_fire;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req   (req_valid_i),
    .i_last  (r_last_idx),
    .o_grant (w_pick),
    .o_found (w_found)
  );

  // Select the owner's byte and encode the one-hot grant back to an index.
  always_comb begin
    w_sel_dat = '0;
    w_gidx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_grant[k]) begin
        w_sel_dat = req_data_i[UART_BYTE_W*k +: UART_BYTE_W];
        w_gidx    = IDX_W'(k);
      end
    end
  end

  assign w_sel_vld  = |(req_valid_i & r_grant);
  assign w_sel_last = |(req_last_i & r_grant);
  assign w_xfer     = (r_state == ST_SEND) && w_sel_vld;
  // A beat accepted on the final watchdog cycle wins over the revoke.
  assign w_wd_fire  = (r_state == ST_SEND) && !w_sel_vld && (r_wd == WD_MAX);

  // State register.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: grant, one byte out, wait for the engine to take it and finish.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (w_found) w_state_nxt = ST_SEND;
      ST_SEND: begin
        if (w_xfer)         w_state_nxt = ST_WAIT_BUSY;
        else if (w_wd_fire) w_state_nxt = ST_IDLE;
      end
      ST_WAIT_BUSY: if (tx_busy_i) w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!tx_busy_i) w_state_nxt = r_last_q ? ST_IDLE : ST_SEND;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: only the owner sees ready, and only while a byte slot is open.
  always_comb begin
    req_ready_o = '0;
    if (r_state == ST_SEND) req_ready_o = req_valid_i & r_grant;
  end

  // Grant ownership, byte capture, start pulse, watchdog and abort counter.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      r_grant    <= '0;
      r_last_idx <= LAST_RST;
      r_wd       <= '0;
      r_tmo_cnt  <= '0;
      r_data     <= '0;
      r_last_q   <= 1'b0;
      r_start    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) r_grant <= w_pick;
        end
        ST_SEND: begin
          if (w_xfer) begin
            r_data   <= w_sel_dat;
            r_last_q <= w_sel_last;
            r_start  <= 1'b1;
            r_wd     <= '0;
          end else if (w_wd_fire) begin
            r_grant    <= '0;
            r_last_idx <= w_gidx;
            r_wd       <= '0;
            if (r_tmo_cnt != TMO_SAT) r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy_i && r_last_q) begin
            r_grant    <= '0;
            r_last_idx <= w_gidx;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant_o       = r_grant;
  assign tx_start_o    = r_start;
  assign tx_data_o     = r_data;
  assign timeout_cnt_o = r_tmo_cnt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomised checks of uart_tx_arbiter with a simple busy-window TX engine model.
// Latency: n/a (testbench).
// Backpressure: requesters hold each byte until valid&ready.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [3:0]  grant;
  logic [3:0]  tmo_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-requester byte queues: bit 8 is the last marker.
  logic [8:0] q     [4][$];
  logic [7:0] exp_b [4][$];
  logic [7:0] got_b [4][$];

  int busy_len        = 10;
  int busy_cnt        = 0;
  int start_busy_viol = 0;
  int ready_viol      = 0;
  int hs_count        = 0;
  int start_count     = 0;
  logic [3:0] drv_hs;

  uart_tx_arbiter #(
    .NUM_REQ     (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .sys_clk_i     (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
    .req_last_i    (req_last),
    .req_ready_o   (req_ready),
    .tx_start_o    (tx_start),
    .tx_data_o     (tx_data),
    .tx_busy_i     (tx_busy),
    .grant_o       (grant),
    .timeout_cnt_o (tmo_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // TX engine model: busy rises the cycle after start and stays up busy_len cycles.
  initial begin
    logic s;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      s = tx_start;
      #1;
      if (rst)               busy_cnt = 0;
      else if (s)            busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
      tx_busy = (busy_cnt != 0);
    end
  end

  // Requester driver: present queue heads, pop on a completed handshake.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(posedge clk);
      drv_hs = req_valid & req_ready;
      #1;
      for (int k = 0; k < 4; k++) begin
        if (drv_hs[k] && q[k].size() > 0) void'(q[k].pop_front());
        if (!rst && q[k].size() > 0) begin
          req_valid[k]       = 1'b1;
          req_data[8*k +: 8] = q[k][0][7:0];
          req_last[k]        = q[k][0][8];
        end else begin
          req_valid[k]       = 1'b0;
          req_data[8*k +: 8] = 8'h00;
          req_last[k]        = 1'b0;
        end
      end
    end
  end

  // Protocol monitor: record transmitted bytes per owner and count rule breaks.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        if (tx_start && tx_busy) start_busy_viol++;
        if (!$onehot0(req_ready) || ((req_ready & ~grant) != 4'b0)) ready_viol++;
        hs_count += $countones(req_valid & req_ready);
        if (tx_start) begin
          start_count++;
          for (int k = 0; k < 4; k++) if (grant[k]) got_b[k].push_back(tx_data);
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL global_timeout: simulation did not complete, got no finish expected finish");
    $fatal(1);
  end

  task automatic clear_queues();
    for (int k = 0; k < 4; k++) q[k].delete();
  endtask

  task automatic wait_grant_nz(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (grant != 4'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_grant_z(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (grant == 4'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_queues();
    repeat (3) @(negedge clk);
    n_checks++; if (grant !== 4'b0)    begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", tx_start); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", tx_data); end
    n_checks++; if (tmo_cnt !== 4'd0)  begin n_fail++; $display("FAIL reset_tmo: got %0d expected 0", tmo_cnt); end
    n_checks++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (grant !== 4'b0) begin n_fail++; $display("FAIL idle_no_req: got %b expected 0000", grant); end
  endtask

  task automatic test_single_frame();
    bit ok;
    int n;
    int sc0;
    sc0 = start_count;
    q[0].push_back({1'b0, 8'h55});
    q[0].push_back({1'b1, 8'hA3});
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_valid[0]) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    n_checks++; if (!ok || grant !== 4'b0001) begin n_fail++; $display("FAIL sf_grant_latency: got %b expected 0001", grant); end
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL sf_ready: got %b expected 0001", req_ready); end
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx_start) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok || tx_data !== 8'h55) begin n_fail++; $display("FAIL sf_byte0: got %h (start seen %0d) expected 55", tx_data, ok); end
    // start, 10 busy cycles, one idle cycle seen by WAIT_DONE, one SEND cycle, then the next start
    n = 0; ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); n++;
      if (tx_start) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok || n != 13) begin n_fail++; $display("FAIL sf_gap: got %0d cycles expected 13", n); end
    n_checks++; if (tx_data !== 8'hA3) begin n_fail++; $display("FAIL sf_byte1: got %h expected a3", tx_data); end
    n = 0; ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); n++;
      if (grant == 4'b0) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok || n != 12 || tx_busy !== 1'b0) begin n_fail++; $display("FAIL sf_release: got %0d cycles busy=%b expected 12 busy=0", n, tx_busy); end
    n_checks++; if (start_count - sc0 != 2) begin n_fail++; $display("FAIL sf_starts: got %0d expected 2", start_count - sc0); end
  endtask

  task automatic test_round_robin();
    bit ok;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    q[0].push_back({1'b1, 8'h10});
    q[2].push_back({1'b1, 8'h20});
    wait_grant_nz(ok);
    n_checks++; if (!ok || grant !== 4'b0001) begin n_fail++; $display("FAIL rr_first: got %b expected 0001", grant); end
    wait_grant_z(ok);
    wait_grant_nz(ok);
    n_checks++; if (!ok || grant !== 4'b0100) begin n_fail++; $display("FAIL rr_second: got %b expected 0100", grant); end
    wait_grant_z(ok);
    q[0].push_back({1'b1, 8'h30});
    wait_grant_nz(ok);
    wait_grant_z(ok);
    // req0 just finished, so from last=0 the tie resolves to req2
    q[0].push_back({1'b1, 8'h40});
    q[2].push_back({1'b1, 8'h50});
    wait_grant_nz(ok);
    n_checks++; if (!ok || grant !== 4'b0100) begin n_fail++; $display("FAIL rr_tie_first: got %b expected 0100", grant); end
    wait_grant_z(ok);
    wait_grant_nz(ok);
    n_checks++; if (!ok || grant !== 4'b0001) begin n_fail++; $display("FAIL rr_tie_second: got %b expected 0001", grant); end
    wait_grant_z(ok);
  endtask

  task automatic test_mid_frame();
    bit ok;
    int bad;
    got_b[1].delete();
    q[1].push_back({1'b0, 8'h31});
    q[1].push_back({1'b0, 8'h32});
    q[1].push_back({1'b1, 8'h33});
    wait_grant_nz(ok);
    n_checks++; if (!ok || grant !== 4'b0010) begin n_fail++; $display("FAIL mf_grant1: got %b expected 0010", grant); end
    q[3].push_back({1'b1, 8'h44});
    bad = 0; ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (grant == 4'b0) begin ok = 1'b1; break; end
      if (req_ready[3]) bad++;
    end
    n_checks++; if (!ok || bad != 0) begin n_fail++; $display("FAIL mf_no_ready3: got %0d ready cycles (done %0d) expected 0", bad, ok); end
    @(negedge clk);
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL mf_grant3: got %b expected 1000", grant); end
    n_checks++;
    if (got_b[1].size() != 3 || got_b[1][0] != 8'h31 || got_b[1][1] != 8'h32 || got_b[1][2] != 8'h33) begin
      n_fail++; $display("FAIL mf_bytes1: got %0d bytes expected 31 32 33", got_b[1].size());
    end
    wait_grant_z(ok);
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    int bad;
    q[2].push_back({1'b0, 8'h11});
    wait_grant_nz(ok);
    n_checks++; if (!ok || grant !== 4'b0100) begin n_fail++; $display("FAIL to_grant: got %b expected 0100", grant); end
    for (int c = 0; c < 30; c++) begin @(negedge clk); if (tx_busy) break; end
    for (int c = 0; c < 30; c++) begin @(negedge clk); if (!tx_busy) break; end
    // busy seen low next edge -> SEND, then 16 idle SEND cycles before the revoke
    n = 0; bad = 0; ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); n++;
      if (grant == 4'b0) begin ok = 1'b1; break; end
      if (grant != 4'b0100 || req_ready != 4'b0) bad++;
    end
    n_checks++; if (!ok || n != 17 || bad != 0) begin n_fail++; $display("FAIL to_revoke: got %0d cycles bad=%0d expected 17 bad=0", n, bad); end
    n_checks++; if (tmo_cnt !== 4'd1) begin n_fail++; $display("FAIL to_count1: got %0d expected 1", tmo_cnt); end
    q[2].push_back({1'b1, 8'h12});
    wait_grant_nz(ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx_start) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok || tx_data !== 8'h12) begin n_fail++; $display("FAIL to_resume: got %h expected 12", tx_data); end
    wait_grant_z(ok);
    for (int i = 0; i < 20; i++) begin
      q[2].push_back({1'b0, 8'(i)});
      wait_grant_nz(ok);
      wait_grant_z(ok);
      if (i == 12) begin
        n_checks++; if (tmo_cnt !== 4'd14) begin n_fail++; $display("FAIL to_count14: got %0d expected 14", tmo_cnt); end
      end
    end
    n_checks++; if (tmo_cnt !== 4'd15) begin n_fail++; $display("FAIL to_saturate: got %0d expected 15", tmo_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    q[0].push_back({1'b1, 8'h60});
    wait_grant_nz(ok);
    wait_grant_z(ok);
    q[1].push_back({1'b0, 8'h61});
    q[1].push_back({1'b1, 8'h62});
    wait_grant_nz(ok);
    n_checks++; if (!ok || grant !== 4'b0010) begin n_fail++; $display("FAIL rm_grant: got %b expected 0010", grant); end
    for (int c = 0; c < 30; c++) begin @(negedge clk); if (tx_busy) break; end
    @(negedge clk);
    rst = 1'b1;
    clear_queues();
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0 || tx_start !== 1'b0 || tx_data !== 8'h00 || tmo_cnt !== 4'd0 || req_ready !== 4'b0) begin
      n_fail++;
      $display("FAIL rm_outputs: got grant=%b start=%b data=%h tmo=%0d ready=%b expected all 0",
               grant, tx_start, tx_data, tmo_cnt, req_ready);
    end
    rst = 1'b0;
    q[0].push_back({1'b1, 8'h70});
    q[1].push_back({1'b1, 8'h71});
    wait_grant_nz(ok);
    n_checks++; if (!ok || grant !== 4'b0001) begin n_fail++; $display("FAIL rm_prio0: got %b expected 0001", grant); end
    wait_grant_z(ok);
    wait_grant_nz(ok);
    n_checks++; if (!ok || grant !== 4'b0010) begin n_fail++; $display("FAIL rm_prio1: got %b expected 0010", grant); end
    wait_grant_z(ok);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int total;
    int k;
    int len;
    int miss;
    logic [7:0] b;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    busy_len = 3;
    for (int i = 0; i < 4; i++) begin got_b[i].delete(); exp_b[i].delete(); end
    start_busy_viol = 0; ready_viol = 0; hs_count = 0; start_count = 0;
    total = 0;
    for (int f = 0; f < 1000; f++) begin
      k   = int'($urandom_range(0, 3));
      len = int'($urandom_range(1, 3));
      for (int j = 0; j < len; j++) begin
        b = 8'($urandom_range(0, 255));
        q[k].push_back({(j == len - 1), b});
        exp_b[k].push_back(b);
        total++;
      end
    end
    ok = 1'b0;
    for (int c = 0; c < 60000; c++) begin
      @(negedge clk);
      if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && q[3].size() == 0 &&
          grant == 4'b0 && !tx_busy) begin
        ok = 1'b1; break;
      end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bb_drain: got not drained expected drained"); end
    n_checks++; if (start_busy_viol != 0) begin n_fail++; $display("FAIL bb_start_busy: got %0d expected 0", start_busy_viol); end
    n_checks++; if (ready_viol != 0) begin n_fail++; $display("FAIL bb_ready_onehot: got %0d expected 0", ready_viol); end
    n_checks++; if (hs_count != start_count || start_count != total) begin
      n_fail++; $display("FAIL bb_counts: got hs=%0d starts=%0d expected %0d", hs_count, start_count, total);
    end
    for (int r = 0; r < 4; r++) begin
      miss = 0;
      if (got_b[r].size() != exp_b[r].size()) miss = 1;
      else for (int j = 0; j < exp_b[r].size(); j++) if (got_b[r][j] != exp_b[r][j]) miss++;
      n_checks++;
      if (miss != 0) begin
        n_fail++;
        $display("FAIL bb_seq_req%0d: got %0d bytes (%0d mismatched) expected %0d", r, got_b[r].size(), miss, exp_b[r].size());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_mid_frame();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
